// File: rtl/operand_stream_feeder_pkg.sv
// Shared types and derived sizes for the operand stream feeder.
package operand_stream_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned LD_W  = 8;

  localparam int unsigned DEF_IFM_SIZE    = 14;
  localparam int unsigned DEF_CI          = 3;
  localparam int unsigned DEF_CO          = 2;
  localparam int unsigned DEF_KERNEL_SIZE = 3;
  localparam int unsigned DEF_PAD         = 0;

  function automatic int unsigned padded_size(input int unsigned size, input int unsigned pad);
    return size + 2 * pad;
  endfunction

  function automatic int unsigned ifm_words(input int unsigned ci, input int unsigned size);
    return ci * size * size;
  endfunction

  function automatic int unsigned pass_words(input int unsigned ci, input int unsigned size,
                                             input int unsigned pad);
    return ci * padded_size(size, pad) * padded_size(size, pad);
  endfunction

  function automatic int unsigned wgt_words(input int unsigned co, input int unsigned ci,
                                            input int unsigned k);
    return co * ci * k * k;
  endfunction

  // Index width for an n-entry memory, never below one bit.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PADDED_SIZE = padded_size(DEF_IFM_SIZE, DEF_PAD);
  localparam int unsigned IFM_WORDS   = ifm_words(DEF_CI, DEF_IFM_SIZE);
  localparam int unsigned PASS_WORDS  = pass_words(DEF_CI, DEF_IFM_SIZE, DEF_PAD);
  localparam int unsigned WGT_WORDS   = wgt_words(DEF_CO, DEF_CI, DEF_KERNEL_SIZE);

endpackage

// File: rtl/stream_counter.sv
// Word position counter with wrap after WRAP words and exhaustion after PASSES wraps.
module stream_counter
  import operand_stream_feeder_pkg::*;
#(
  parameter int unsigned WRAP   = 1,
  parameter int unsigned PASSES = 1
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             adv,
  output logic [CNT_W-1:0] cnt,
  output logic             last_c,
  output logic             exh
);

  logic [CNT_W-1:0] pass_cnt;
  logic             wrap_c;

  // wrap_c: current word is the last of a pass; last_c: last word of the whole stream
  assign wrap_c = (cnt == CNT_W'(WRAP - 1));
  assign last_c = wrap_c && (pass_cnt == CNT_W'(PASSES - 1)) && !exh;

  // Position, pass and exhaustion tracking
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      pass_cnt <= '0;
      exh      <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      pass_cnt <= '0;
      exh      <= 1'b0;
    end else if (adv && !exh) begin
      if (wrap_c) begin
        cnt      <= '0;
        pass_cnt <= pass_cnt + 1'b1;
        if (last_c) exh <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_stream_feeder.sv
// Replays a (optionally zero-padded) IFM and a weight set as two read-on-demand streams.
module operand_stream_feeder
  import operand_stream_feeder_pkg::*;
#(
  parameter int unsigned IFM_WIDTH    = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned IFM_SIZE     = DEF_IFM_SIZE,
  parameter int unsigned CI           = DEF_CI,
  parameter int unsigned CO           = DEF_CO,
  parameter int unsigned KERNEL_SIZE  = DEF_KERNEL_SIZE,
  parameter int unsigned PAD          = DEF_PAD,
  parameter int unsigned IFM_PASSES   = CO
) (
  input  logic                    clk2,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    ifm_read,
  input  logic                    wgt_read,
  output logic [IFM_WIDTH-1:0]    ifm_data,
  output logic                    ifm_valid,
  output logic [WEIGHT_WIDTH-1:0] wgt_data,
  output logic                    wgt_valid,
  input  logic                    ld_en,
  input  logic                    ld_sel,
  input  logic [CNT_W-1:0]        ld_addr,
  input  logic [LD_W-1:0]         ld_data,
  output logic                    busy,
  output logic                    done,
  output logic                    ovr_err
);

  localparam int unsigned P_SIZE  = padded_size(IFM_SIZE, PAD);
  localparam int unsigned PLANE   = P_SIZE * P_SIZE;
  localparam int unsigned SQ      = IFM_SIZE * IFM_SIZE;
  localparam int unsigned I_WORDS = ifm_words(CI, IFM_SIZE);
  localparam int unsigned P_WORDS = pass_words(CI, IFM_SIZE, PAD);
  localparam int unsigned W_WORDS = wgt_words(CO, CI, KERNEL_SIZE);
  localparam int unsigned IAW     = addr_bits(I_WORDS);
  localparam int unsigned WAW     = addr_bits(W_WORDS);

  state_e state_q, state_d;

  logic [IFM_WIDTH-1:0]    ifm_mem [I_WORDS];
  logic [WEIGHT_WIDTH-1:0] wgt_mem [W_WORDS];

  logic [CNT_W-1:0] ifm_cnt, wgt_cnt;
  logic [CNT_W-1:0] ch, rem, row, col, ifm_addr;
  logic             ifm_border;
  logic             ifm_exh, ifm_last_c, wgt_exh, wgt_last_c;
  logic             cnt_clr, ifm_adv, wgt_adv;

  logic [IFM_WIDTH-1:0]    ifm_word_c, ifm_data_d;
  logic [WEIGHT_WIDTH-1:0] wgt_word_c, wgt_data_d;
  logic                    ifm_valid_d, wgt_valid_d, ovr_err_d;

  stream_counter #(.WRAP(P_WORDS), .PASSES(IFM_PASSES)) u_ifm_cnt (
    .clk2   (clk2),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .adv    (ifm_adv),
    .cnt    (ifm_cnt),
    .last_c (ifm_last_c),
    .exh    (ifm_exh)
  );

  stream_counter #(.WRAP(W_WORDS), .PASSES(1)) u_wgt_cnt (
    .clk2   (clk2),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .adv    (wgt_adv),
    .cnt    (wgt_cnt),
    .last_c (wgt_last_c),
    .exh    (wgt_exh)
  );

  // Padded-image coordinates of the current IFM position
  assign ch       = ifm_cnt / CNT_W'(PLANE);
  assign rem      = ifm_cnt % CNT_W'(PLANE);
  assign row      = rem / CNT_W'(P_SIZE);
  assign col      = rem % CNT_W'(P_SIZE);
  assign ifm_addr = ch * CNT_W'(SQ) + (row - CNT_W'(PAD)) * CNT_W'(IFM_SIZE) + (col - CNT_W'(PAD));

  generate
    if (PAD == 0) begin : g_nopad
      assign ifm_border = 1'b0;
    end else begin : g_pad
      assign ifm_border = (row < CNT_W'(PAD)) || (row >= CNT_W'(PAD + IFM_SIZE)) ||
                          (col < CNT_W'(PAD)) || (col >= CNT_W'(PAD + IFM_SIZE));
    end
  endgenerate

  assign ifm_word_c = ifm_border ? '0 : ifm_mem[IAW'(ifm_addr)];
  assign wgt_word_c = wgt_mem[WAW'(wgt_cnt)];

  // Load port: writes only outside a session, out-of-range addresses dropped
  always_ff @(posedge clk2) begin
    if (ld_en && (state_q != ST_RUN)) begin
      if (!ld_sel && (ld_addr < CNT_W'(I_WORDS))) ifm_mem[IAW'(ld_addr)] <= IFM_WIDTH'(ld_data);
      if (ld_sel && (ld_addr < CNT_W'(W_WORDS))) wgt_mem[WAW'(ld_addr)] <= WEIGHT_WIDTH'(ld_data);
    end
  end

  // Next state, stream advance and next output values
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    ifm_adv     = 1'b0;
    wgt_adv     = 1'b0;
    ifm_valid_d = 1'b0;
    ifm_data_d  = '0;
    wgt_valid_d = 1'b0;
    wgt_data_d  = '0;
    ovr_err_d   = ovr_err;
    if (start) begin
      state_d   = ST_RUN;
      cnt_clr   = 1'b1;
      ovr_err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ifm_read) begin
            if (ifm_exh) begin
              ovr_err_d = 1'b1;
            end else begin
              ifm_adv     = 1'b1;
              ifm_valid_d = 1'b1;
              ifm_data_d  = ifm_word_c;
            end
          end
          if (wgt_read) begin
            if (wgt_exh) begin
              ovr_err_d = 1'b1;
            end else begin
              wgt_adv     = 1'b1;
              wgt_valid_d = 1'b1;
              wgt_data_d  = wgt_word_c;
            end
          end
          if ((ifm_exh || (ifm_read && ifm_last_c)) && (wgt_exh || (wgt_read && wgt_last_c)))
            state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ifm_valid <= 1'b0;
      ifm_data  <= '0;
      wgt_valid <= 1'b0;
      wgt_data  <= '0;
      ovr_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ifm_valid <= ifm_valid_d;
      ifm_data  <= ifm_data_d;
      wgt_valid <= wgt_valid_d;
      wgt_data  <= wgt_data_d;
      ovr_err   <= ovr_err_d;
      busy      <= (state_d == ST_RUN);
      done      <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_operand_stream_feeder.sv
// Bench for operand_stream_feeder: default instance against a stream model, plus a padded instance.
module tb_operand_stream_feeder;
  import operand_stream_feeder_pkg::*;

  localparam int unsigned IFM_TOTAL = PASS_WORDS * DEF_CO;
  localparam int unsigned P1_SIZE   = 6;
  localparam int unsigned P1_PASS   = P1_SIZE * P1_SIZE;
  localparam int unsigned P1_MEM    = 16;
  localparam int unsigned P1_WGT    = 18;

  logic clk2 = 1'b0;
  logic rst_n;
  always #5 clk2 = ~clk2;

  // default instance
  logic start, ifm_read, wgt_read, ld_en, ld_sel;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data, ifm_data, wgt_data;
  logic ifm_valid, wgt_valid, busy, done, ovr_err;

  // padded instance
  logic p_start, p_ifm_read, p_wgt_read, p_ld_en, p_ld_sel;
  logic [31:0] p_ld_addr;
  logic [7:0]  p_ld_data, p_ifm_data, p_wgt_data;
  logic p_ifm_valid, p_wgt_valid, p_busy, p_done, p_ovr_err;

  operand_stream_feeder dut (
    .clk2(clk2), .rst_n(rst_n), .start(start), .ifm_read(ifm_read), .wgt_read(wgt_read),
    .ifm_data(ifm_data), .ifm_valid(ifm_valid), .wgt_data(wgt_data), .wgt_valid(wgt_valid),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .done(done), .ovr_err(ovr_err)
  );

  operand_stream_feeder #(.IFM_SIZE(4), .CI(1), .PAD(1)) dut_pad (
    .clk2(clk2), .rst_n(rst_n), .start(p_start), .ifm_read(p_ifm_read), .wgt_read(p_wgt_read),
    .ifm_data(p_ifm_data), .ifm_valid(p_ifm_valid), .wgt_data(p_wgt_data), .wgt_valid(p_wgt_valid),
    .ld_en(p_ld_en), .ld_sel(p_ld_sel), .ld_addr(p_ld_addr), .ld_data(p_ld_data),
    .busy(p_busy), .done(p_done), .ovr_err(p_ovr_err)
  );

  // reference model of the default instance
  logic [7:0]  m_ifm [IFM_WORDS];
  logic [7:0]  m_wgt [WGT_WORDS];
  logic [7:0]  p1_mem [P1_MEM];
  bit          m_run, m_fin;
  int unsigned ik, wk;
  bit          e_iv, e_wv, e_ovr;
  logic [7:0]  e_id, e_wd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         ir;
    bit         wr;
    bit         iv;
    logic [7:0] id;
    bit         wv;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("ifm_valid", 32'(ifm_valid), 32'(e_iv));
    chk("ifm_data",  32'(ifm_data),  32'(e_id));
    chk("wgt_valid", 32'(wgt_valid), 32'(e_wv));
    chk("wgt_data",  32'(wgt_data),  32'(e_wd));
    chk("busy",      32'(busy),      32'(m_run));
    chk("done",      32'(done),      32'(m_fin));
    chk("ovr_err",   32'(ovr_err),   32'(e_ovr));
  endtask

  task automatic model_reset();
    m_run = 0; m_fin = 0; ik = 0; wk = 0;
    e_iv = 0; e_wv = 0; e_ovr = 0; e_id = 0; e_wd = 0;
  endtask

  // advance the model by the inputs now applied, clock once, compare
  task automatic cycle();
    if (ld_en && !m_run) begin
      if (!ld_sel && ld_addr < IFM_WORDS) m_ifm[ld_addr] = ld_data;
      if (ld_sel && ld_addr < WGT_WORDS) m_wgt[ld_addr] = ld_data;
    end
    e_iv = 0; e_id = 0; e_wv = 0; e_wd = 0;
    if (start) begin
      m_run = 1; m_fin = 0; ik = 0; wk = 0; e_ovr = 0;
    end else if (m_run) begin
      if (ifm_read) begin
        if (ik < IFM_TOTAL) begin
          e_iv = 1; e_id = m_ifm[ik % PASS_WORDS]; ik++;
        end else e_ovr = 1;
      end
      if (wgt_read) begin
        if (wk < WGT_WORDS) begin
          e_wv = 1; e_wd = m_wgt[wk]; wk++;
        end else e_ovr = 1;
      end
      if (ik == IFM_TOTAL && wk == WGT_WORDS) begin
        m_run = 0; m_fin = 1;
      end
    end
    @(posedge clk2);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    start = 0; ifm_read = 0; wgt_read = 0; ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
  endtask

  // expected padded-instance word for global read index k
  function automatic logic [7:0] exp_pad(input int unsigned k);
    int unsigned pos, r, c;
    pos = k % P1_PASS;
    r = pos / P1_SIZE;
    c = pos % P1_SIZE;
    if (r < 1 || r > 4 || c < 1 || c > 4) return 8'd0;
    return p1_mem[(r - 1) * 4 + (c - 1)];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 0;
    idle_inputs();
    p_start = 0; p_ifm_read = 0; p_wgt_read = 0; p_ld_en = 0; p_ld_sel = 0;
    p_ld_addr = 0; p_ld_data = 0;
    model_reset();
    #12;
    check_outputs();
    chk("pad_rst_valid", 32'(p_ifm_valid), 32'd0);
    chk("pad_rst_busy",  32'(p_busy),      32'd0);
    @(negedge clk2);
    rst_n = 1;

    // load both instances
    for (int i = 0; i < int'(IFM_WORDS); i++) begin
      ld_en = 1; ld_sel = 0; ld_addr = 32'(i); ld_data = 8'(i);
      if (i < int'(P1_MEM)) begin
        p_ld_en = 1; p_ld_sel = 0; p_ld_addr = 32'(i); p_ld_data = 8'($urandom_range(1, 255));
        p1_mem[i] = p_ld_data;
      end else if (i < int'(P1_MEM + P1_WGT)) begin
        p_ld_en = 1; p_ld_sel = 1; p_ld_addr = 32'(i - int'(P1_MEM)); p_ld_data = 8'(i);
      end else p_ld_en = 0;
      cycle();
    end
    p_ld_en = 0;
    for (int i = 0; i < int'(WGT_WORDS); i++) begin
      ld_en = 1; ld_sel = 1; ld_addr = 32'(i); ld_data = 8'(i);
      cycle();
    end
    // out-of-range addresses that alias to index 0 if not range-checked
    ld_sel = 0; ld_addr = 32'd1024; ld_data = 8'hFF; cycle();
    ld_sel = 1; ld_addr = 32'd64;   ld_data = 8'hFF; cycle();
    idle_inputs();

    // session 1: table-driven opening reads
    tbl[0] = '{0, 0, 0, 8'd0, 0, 8'd0};
    tbl[1] = '{1, 0, 1, 8'd0, 0, 8'd0};
    tbl[2] = '{1, 1, 1, 8'd1, 1, 8'd0};
    tbl[3] = '{0, 1, 0, 8'd0, 1, 8'd1};
    tbl[4] = '{0, 0, 0, 8'd0, 0, 8'd0};
    tbl[5] = '{1, 1, 1, 8'd2, 1, 8'd2};
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 6; i++) begin
      ifm_read = tbl[i].ir; wgt_read = tbl[i].wr;
      cycle();
      chk("tbl_ifm_valid", 32'(ifm_valid), 32'(tbl[i].iv));
      chk("tbl_ifm_data",  32'(ifm_data),  32'(tbl[i].id));
      chk("tbl_wgt_valid", 32'(wgt_valid), 32'(tbl[i].wv));
      chk("tbl_wgt_data",  32'(wgt_data),  32'(tbl[i].wd));
    end

    // session 2: random read pattern until both streams are exhausted
    ifm_read = 0; wgt_read = 0;
    start = 1; cycle(); start = 0;
    for (int n = 0; n < 6000 && !m_fin; n++) begin
      ifm_read = ($urandom_range(0, 99) < 75);
      wgt_read = ($urandom_range(0, 99) < 8);
      cycle();
    end
    if (!m_fin) begin
      total++; bad++;
      $display("FAIL random_session_timeout: got done=0 expected done=1");
    end
    for (int n = 0; n < 3; n++) begin
      ifm_read = 1; wgt_read = 1; cycle();
    end

    // session 3: IFM exhausted first, over-read, then weights
    ifm_read = 0; wgt_read = 0;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < int'(IFM_TOTAL); i++) begin
      ifm_read = 1; cycle();
    end
    chk("ifm_exhausted_still_busy", 32'(busy), 32'd1);
    ifm_read = 1; cycle();
    chk("overread_valid", 32'(ifm_valid), 32'd0);
    chk("overread_ovr",   32'(ovr_err),   32'd1);
    ifm_read = 0;
    for (int i = 0; i < int'(WGT_WORDS); i++) begin
      wgt_read = 1; cycle();
    end
    chk("done_at_last_word", 32'(done), 32'd1);
    wgt_read = 0;

    // session 4: start wins over a same-cycle read at position 100
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 100; i++) begin
      ifm_read = 1; cycle();
    end
    start = 1; ifm_read = 1; cycle();
    chk("prio_no_valid", 32'(ifm_valid), 32'd0);
    start = 0; ifm_read = 1; cycle();
    chk("prio_restart_word", 32'(ifm_data), 32'(m_ifm[0]));

    // load attempt during RUN, then asynchronous reset mid-session
    ld_en = 1; ld_sel = 0; ld_addr = 32'd0; ld_data = 8'hAA; ifm_read = 1; wgt_read = 1;
    cycle();
    idle_inputs();
    rst_n = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk2);
    rst_n = 1;
    ifm_read = 1; cycle();
    chk("idle_read_valid", 32'(ifm_valid), 32'd0);
    ifm_read = 0; start = 1; cycle(); start = 0;
    ifm_read = 1; cycle();
    chk("mem_kept_after_run_load", 32'(ifm_data), 32'(m_ifm[0]));
    idle_inputs();
    cycle();

    // padded instance: 2 passes of 36 words, then one over-read
    @(negedge clk2);
    p_start = 1;
    @(posedge clk2); #1;
    p_start = 0;
    chk("pad_busy", 32'(p_busy), 32'd1);
    for (int k = 0; k < int'(2 * P1_PASS); k++) begin
      p_ifm_read = 1;
      @(posedge clk2); #1;
      chk("pad_valid", 32'(p_ifm_valid), 32'd1);
      chk("pad_data",  32'(p_ifm_data),  32'(exp_pad(k)));
    end
    @(posedge clk2); #1;
    chk("pad_overread_valid", 32'(p_ifm_valid), 32'd0);
    chk("pad_overread_data",  32'(p_ifm_data),  32'd0);
    chk("pad_overread_ovr",   32'(p_ovr_err),   32'd1);
    p_ifm_read = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_stream_feeder.md
OPERAND_STREAM_FEEDER -- requirements
Module: operand_stream_feeder

Interface
REQ-001 Parameters SHALL be IFM_WIDTH, default 8, IFM word width.
REQ-002 WEIGHT_WIDTH SHALL default to 8, weight word width.
REQ-003 IFM_SIZE SHALL default to 14, unpadded IFM height and width.
REQ-004 CI SHALL default to 3, input channels; CO SHALL default to 2, output filters; KERNEL_SIZE SHALL default to 3.
REQ-005 PAD SHALL default to 0, zero border inserted on each side.
REQ-006 IFM_PASSES SHALL default to CO, number of full IFM replays.
REQ-007 Ports (clock and reset first):
- clk2  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin/restart a stream session.
- ifm_read  in  1  IFM word request.
- wgt_read  in  1  weight word request.
- ifm_data  out  IFM_WIDTH  IFM word.
- ifm_valid  out  1  ifm_data qualifier.
- wgt_data  out  WEIGHT_WIDTH  weight word.
- wgt_valid  out  1  wgt_data qualifier.
- ld_en  in  1  load-port write strobe.
- ld_sel  in  1  load target: 0 = IFM memory, 1 = weight memory.
- ld_addr  in  32  load address.
- ld_data  in  8  load word, truncated to target width.
- busy  out  1  session active.
- done  out  1  both streams exhausted.
- ovr_err  out  1  sticky read-after-exhaustion flag.

Function
REQ-008 Storage SHALL be an IFM memory of CI*IFM_SIZE^2 words and a weight memory of CO*CI*KERNEL_SIZE^2 words.
REQ-009 The FSM SHALL have states IDLE, RUN and DONE.
REQ-010 start in any state SHALL enter RUN and clear the IFM count, weight count, pass count, exhaustion flags and ovr_err; start SHALL take priority over a same-cycle read.
REQ-011 In RUN, ifm_read SHALL produce ifm_valid=1 on the next clk2 edge (1-cycle latency), with ifm_data taken from the current IFM position; the IFM count SHALL then increment.
REQ-012 IFM order SHALL be channel-major, then row, then column, over the padded image of (IFM_SIZE+2*PAD)^2 positions per channel.
REQ-013 A padded-border position SHALL output 0 with ifm_valid=1; an interior position SHALL map to memory[c*IFM_SIZE^2 + (r-PAD)*IFM_SIZE + (col-PAD)].
REQ-014 On delivery of the last padded-IFM word of a pass, the IFM count SHALL wrap to 0 and the pass count SHALL increment.
REQ-015 When the pass count reaches IFM_PASSES, the IFM stream SHALL be exhausted.
REQ-016 In RUN, wgt_read SHALL produce wgt_valid=1 with memory[wgt_cnt] on the next edge, then increment wgt_cnt.
REQ-017 The weight stream SHALL be exhausted after CO*CI*KERNEL_SIZE^2 words (single pass, no wrap).
REQ-018 A read of an exhausted stream, or any read outside RUN, SHALL give valid=0 and data=0.
REQ-019 A read of an exhausted stream while in RUN SHALL also set ovr_err.
REQ-020 Simultaneous ifm_read and wgt_read SHALL both be served in the same cycle.
REQ-021 When valid=0, the corresponding data output SHALL be 0.
REQ-022 RUN SHALL go to DONE on the edge where the second stream becomes exhausted.
REQ-023 done SHALL be high in DONE only; busy SHALL be high in RUN only.
REQ-024 ld_en SHALL write only in IDLE or DONE; it SHALL be ignored in RUN, and out-of-range ld_addr SHALL be ignored.
REQ-025 Counters SHALL be 32-bit unsigned and address arithmetic SHALL not overflow for the default parameters.

Reset
REQ-026 Asserting rst_n low SHALL immediately force state IDLE and clear all counters.
REQ-027 Reset SHALL force ifm_valid, wgt_valid, busy, done and ovr_err to 0, and ifm_data and wgt_data to 0.
REQ-028 Memory contents SHALL be unaffected by reset.
REQ-029 Reset mid-RUN SHALL abandon the session; a new start is required.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE/RUN/DONE) and derived constants PADDED_SIZE, IFM_WORDS, PASS_WORDS and WGT_WORDS.
REQ-031 One sub-module, stream_counter (parametrised wrap count with wrap/exhaust outputs), SHALL be instantiated once per stream.

Verification
REQ-032 Defaults, load IFM with values i mod 256 and weights with i, then start and read 588 IFM words -> data sequence 0..587 mod 256, valid lagging by 1 cycle, pass count 1.
REQ-033 Defaults, 1176 IFM reads interleaved with 54 weight reads -> done=1 on the edge after the last word; a 1177th read -> ifm_valid=0 and ovr_err=1.
REQ-034 PAD=1, IFM_SIZE=4, CI=1 -> first 7 words are 0, the 8th equals memory[0], and 36 words per pass.
REQ-035 Assert start in the same cycle as ifm_read at IFM position 100 -> no valid next cycle, counts reset, and the next read returns memory[0].
REQ-036 Drop rst_n mid-RUN -> all outputs 0 at once and IDLE entered; ld_en in RUN leaves memory unchanged, checked by re-reading after restart.
